// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: sequencer states, port indices, timer width.
// Pure declarations; no timing or backpressure of its own.
package sram_arb_pkg;

    localparam int CNT_W = 4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_VID = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        W_SETUP,
        W_PULSE,
        W_HOLD
    } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// CPU, video and SRAM-pin signal bundle of the arbiter; master = system side, slave = arbiter.
// Requests are level-held until the matching one-cycle ack pulse.
interface sram_arbiter_if #(
    parameter int ADDR_W = 21
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [7:0]        vid_rdata;

    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we_n;
    logic [7:0]        sram_dq_o;
    logic              sram_dq_oe;
    logic [7:0]        sram_dq_i;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_dq_i,
        input  cpu_ack, cpu_rdata, vid_ack, vid_rdata,
        input  sram_addr, sram_we_n, sram_dq_o, sram_dq_oe
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_dq_i,
        output cpu_ack, cpu_rdata, vid_ack, vid_rdata,
        output sram_addr, sram_we_n, sram_dq_o, sram_dq_oe
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port (CPU r/w, video r/o) arbiter and cycle sequencer for an async 8-bit SRAM; all outputs registered.
// Read acks ACCESS_CYCLES+1 after grant cycle, write ACCESS_CYCLES+3; losing port waits at most one access.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 21,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic            clk_100,
    input  logic            reset,
    sram_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_sram_addr;
    logic              r_sram_we_n;
    logic [7:0]        r_sram_dq_o;
    logic              r_sram_dq_oe;
    logic              r_cpu_ack;
    logic              r_vid_ack;
    logic [7:0]        r_cpu_rdata;
    logic [7:0]        r_vid_rdata;

    // A port's own ack cycle masks its still-high level request.
    logic w_cpu_pend;
    logic w_vid_pend;
    logic w_grant_vid;

    assign w_cpu_pend  = bus.cpu_req & ~r_cpu_ack;
    assign w_vid_pend  = bus.vid_req & ~r_vid_ack;
    assign w_grant_vid = w_vid_pend & (~w_cpu_pend | (r_last_grant == PORT_CPU));

    always_ff @(posedge clk_100) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= PORT_CPU;
            r_sram_addr  <= '0;
            r_sram_we_n  <= 1'b1;
            r_sram_dq_o  <= '0;
            r_sram_dq_oe <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_vid_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_vid_rdata  <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_vid_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cpu_pend || w_vid_pend) begin
                        r_cnt <= CNT_LOAD;
                        if (w_grant_vid) begin
                            r_sram_addr  <= bus.vid_addr;
                            r_last_grant <= PORT_VID;
                            r_state      <= RD;
                        end else begin
                            r_sram_addr  <= bus.cpu_addr;
                            r_last_grant <= PORT_CPU;
                            if (bus.cpu_we) begin
                                r_sram_dq_o  <= bus.cpu_wdata;
                                r_sram_dq_oe <= 1'b1;
                                r_state      <= W_SETUP;
                            end else begin
                                r_state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (r_cnt == '0) begin
                        if (r_last_grant == PORT_VID) begin
                            r_vid_rdata <= bus.sram_dq_i;
                            r_vid_ack   <= 1'b1;
                        end else begin
                            r_cpu_rdata <= bus.sram_dq_i;
                            r_cpu_ack   <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                W_SETUP: begin
                    r_sram_we_n <= 1'b0;
                    r_state     <= W_PULSE;
                end
                W_PULSE: begin
                    if (r_cnt == '0) begin
                        r_sram_we_n <= 1'b1;
                        r_state     <= W_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                W_HOLD: begin
                    r_sram_dq_oe <= 1'b0;
                    r_cpu_ack    <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_we_n  = r_sram_we_n;
    assign bus.sram_dq_o  = r_sram_dq_o;
    assign bus.sram_dq_oe = r_sram_dq_oe;
    assign bus.cpu_ack    = r_cpu_ack;
    assign bus.vid_ack    = r_vid_ack;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.vid_rdata  = r_vid_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, hand-built corner sequences and random two-port traffic
// against a transaction-level memory model; a second instance runs with ACCESS_CYCLES=1.
module tb_sram_arbiter;

    logic clk_100 = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_100 = ~clk_100;

    sram_arbiter_if #(.ADDR_W(21)) b0 ();
    sram_arbiter_if #(.ADDR_W(21)) b1 ();

    sram_arbiter #(.ADDR_W(21), .ACCESS_CYCLES(2)) u_dut0 (.clk_100(clk_100), .reset(reset), .bus(b0));
    sram_arbiter #(.ADDR_W(21), .ACCESS_CYCLES(1)) u_dut1 (.clk_100(clk_100), .reset(reset), .bus(b1));

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [20:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'hA5;
    endfunction

    // Pin-level SRAM models: write while WE_n low, async read of the current address.
    logic [7:0] mem [int];
    always @(negedge clk_100) begin
        if (!b0.sram_we_n) mem[int'(b0.sram_addr)] = b0.sram_dq_o;
        b0.sram_dq_i = mem.exists(int'(b0.sram_addr)) ? mem[int'(b0.sram_addr)] : pat(b0.sram_addr);
        b1.sram_dq_i = pat(b1.sram_addr);
    end

    // Transaction-level reference: contents as seen by completed CPU writes.
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] ref_rd(input logic [20:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
    endfunction

    logic [20:0] prev_addr;
    logic [7:0]  prev_dq;
    int          n_cpu_acks = 0;
    int          n_vid_acks = 0;
    logic        log_en = 1'b0;
    logic        ack_log [$];

    always @(negedge clk_100) begin
        if (!reset && !b0.sram_we_n) begin
            chk("we_low_needs_oe", b0.sram_dq_oe, 1);
            chk("we_low_addr_stable", b0.sram_addr, prev_addr);
            chk("we_low_data_stable", b0.sram_dq_o, prev_dq);
        end
        prev_addr = b0.sram_addr;
        prev_dq   = b0.sram_dq_o;
        if (b0.cpu_ack) n_cpu_acks++;
        if (b0.vid_ack) n_vid_acks++;
        if (log_en && b0.cpu_ack) ack_log.push_back(1'b0);
        if (log_en && b0.vid_ack) ack_log.push_back(1'b1);
    end

    // Caller is 1 time unit after a rising edge; that cycle is the request cycle.
    task automatic txn(input logic vid, input logic we, input logic [20:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd, output int we_low, output int oe_cnt,
                       output logic [20:0] a_t1);
        logic done;
        lat = 0; we_low = 0; oe_cnt = 0; done = 1'b0; a_t1 = '0;
        if (vid) begin
            b0.vid_req = 1'b1; b0.vid_addr = a;
        end else begin
            b0.cpu_req = 1'b1; b0.cpu_we = we; b0.cpu_addr = a; b0.cpu_wdata = d;
        end
        while (!done && lat < 60) begin
            @(posedge clk_100); #1;
            lat++;
            if (lat == 1) a_t1 = b0.sram_addr;
            if (!b0.sram_we_n) we_low++;
            if (b0.sram_dq_oe) oe_cnt++;
            done = vid ? b0.vid_ack : b0.cpu_ack;
        end
        rd = vid ? b0.vid_rdata : b0.cpu_rdata;
        if (vid) b0.vid_req = 1'b0; else b0.cpu_req = 1'b0;
    endtask

    task automatic txn1(input logic we, input logic [20:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output int we_low, output logic [7:0] dq_we);
        logic done;
        lat = 0; we_low = 0; done = 1'b0; dq_we = '0;
        b1.cpu_req = 1'b1; b1.cpu_we = we; b1.cpu_addr = a; b1.cpu_wdata = d;
        while (!done && lat < 60) begin
            @(posedge clk_100); #1;
            lat++;
            if (!b1.sram_we_n) begin
                we_low++;
                dq_we = b1.sram_dq_o;
            end
            done = b1.cpu_ack;
        end
        rd = b1.cpu_rdata;
        b1.cpu_req = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_100); #1;
    endtask

    typedef struct {
        logic        vid;
        logic        we;
        logic [20:0] addr;
        logic [7:0]  wdata;
        int          exp_lat;
        logic [7:0]  exp_rd;
        int          exp_we_low;
        int          exp_oe;
    } vec_t;

    vec_t vt [7];

    initial begin
        int lat, wl, oc, lat2;
        logic [7:0] rd, rd2;
        logic [20:0] at1, at1b;
        logic [7:0] dqw;

        b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
        b0.vid_req = 0; b0.vid_addr = '0;
        b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
        b1.vid_req = 0; b1.vid_addr = '0;
        mem[int'(21'h012345)]     = 8'h5A;
        ref_mem[int'(21'h012345)] = 8'h5A;

        vt[0] = '{1'b0, 1'b0, 21'h012345, 8'h00, 3, 8'h5A, 0, 0};
        vt[1] = '{1'b0, 1'b1, 21'h1FFFFF, 8'hC3, 5, 8'h5A, 2, 4};
        vt[2] = '{1'b0, 1'b0, 21'h1FFFFF, 8'h00, 3, 8'hC3, 0, 0};
        vt[3] = '{1'b1, 1'b0, 21'h012345, 8'h00, 3, 8'h5A, 0, 0};
        vt[4] = '{1'b0, 1'b1, 21'h0ABCDE, 8'h3C, 5, 8'hC3, 2, 4};
        vt[5] = '{1'b1, 1'b0, 21'h0ABCDE, 8'h00, 3, 8'h3C, 0, 0};
        vt[6] = '{1'b1, 1'b0, 21'h000000, 8'h00, 3, 8'hA5, 0, 0};

        repeat (2) next_cycle();
        chk("rst_sram_addr", b0.sram_addr, 0);
        chk("rst_we_n", b0.sram_we_n, 1);
        chk("rst_dq_o", b0.sram_dq_o, 0);
        chk("rst_dq_oe", b0.sram_dq_oe, 0);
        chk("rst_cpu_ack", b0.cpu_ack, 0);
        chk("rst_vid_ack", b0.vid_ack, 0);
        chk("rst_cpu_rdata", b0.cpu_rdata, 0);
        chk("rst_vid_rdata", b0.vid_rdata, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            txn(vt[i].vid, vt[i].we, vt[i].addr, vt[i].wdata, lat, rd, wl, oc, at1);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_addr_t1", i), at1, vt[i].addr);
            chk($sformatf("vec%0d_we_low_cycles", i), wl, vt[i].exp_we_low);
            chk($sformatf("vec%0d_oe_cycles", i), oc, vt[i].exp_oe);
            if (vt[i].we) ref_mem[int'(vt[i].addr)] = vt[i].wdata;
            next_cycle();
        end

        txn1(1'b0, 21'h000777, 8'h00, lat, rd, wl, dqw);
        chk("ac1_read_latency", lat, 2);
        chk("ac1_read_rdata", rd, pat(21'h000777));
        next_cycle();
        txn1(1'b1, 21'h000100, 8'h99, lat, rd, wl, dqw);
        chk("ac1_write_latency", lat, 4);
        chk("ac1_we_low_cycles", wl, 1);
        chk("ac1_write_data", dqw, 8'h99);
        next_cycle();

        // Tie straight after reset: video wins, CPU granted in the video ack cycle.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        fork
            txn(1'b1, 1'b0, 21'h000123, 8'h00, lat, rd, wl, oc, at1);
            txn(1'b0, 1'b0, 21'h012345, 8'h00, lat2, rd2, wl, oc, at1b);
        join
        chk("tie_vid_latency", lat, 3);
        chk("tie_vid_addr_t1", at1, 21'h000123);
        chk("tie_vid_rdata", rd, pat(21'h000123));
        chk("tie_cpu_latency", lat2, 6);
        chk("tie_cpu_rdata", rd2, 8'h5A);

        log_en = 1'b1;
        fork
            for (int k = 0; k < 8; k++) begin
                int l; logic [7:0] r; int w, o; logic [20:0] t;
                txn(1'b1, 1'b0, 21'h000180 + 21'(k), 8'h00, l, r, w, o, t);
                chk("alt_vid_rdata", r, pat(21'h000180 + 21'(k)));
            end
            for (int k = 0; k < 8; k++) begin
                int l; logic [7:0] r; int w, o; logic [20:0] t;
                txn(1'b0, 1'b0, 21'h012345, 8'h00, l, r, w, o, t);
                chk("alt_cpu_rdata", r, 8'h5A);
            end
        join
        log_en = 1'b0;
        chk("alt_ack_count", ack_log.size(), 16);
        for (int k = 1; k < ack_log.size(); k++)
            chk($sformatf("alt_grant_%0d", k), ack_log[k] != ack_log[k-1], 1);
        next_cycle();

        // Reset in the middle of the WE_n pulse, with a new write held through reset.
        b0.cpu_req = 1'b1; b0.cpu_we = 1'b1; b0.cpu_addr = 21'h0ABC00; b0.cpu_wdata = 8'h11;
        next_cycle();
        next_cycle();
        chk("abort_in_pulse", b0.sram_we_n, 0);
        reset = 1'b1;
        b0.cpu_addr = 21'h0ABC01; b0.cpu_wdata = 8'h77;
        next_cycle();
        chk("abort_we_n", b0.sram_we_n, 1);
        chk("abort_dq_oe", b0.sram_dq_oe, 0);
        chk("abort_no_ack_1", b0.cpu_ack, 0);
        next_cycle();
        chk("abort_no_ack_2", b0.cpu_ack, 0);
        reset = 1'b0;
        txn(1'b0, 1'b1, 21'h0ABC01, 8'h77, lat, rd, wl, oc, at1);
        chk("post_reset_write_latency", lat, 5);
        chk("post_reset_we_low_cycles", wl, 2);
        chk("post_reset_mem", mem.exists(int'(21'h0ABC01)) ? mem[int'(21'h0ABC01)] : 9'h100, 8'h77);
        ref_mem[int'(21'h0ABC01)] = 8'h77;
        next_cycle();

        fork
            for (int k = 0; k < 30; k++) begin
                int l, w, o, base, gap; logic [7:0] r, d, e; logic [20:0] a, t; logic we;
                gap = $urandom_range(0, 3);
                repeat (gap) next_cycle();
                we = 1'($urandom_range(0, 1));
                a  = 21'h100000 + 21'($urandom_range(0, 15));
                d  = 8'($urandom);
                e  = ref_rd(a);
                if (we) ref_mem[int'(a)] = d;
                base = n_vid_acks;
                txn(1'b0, we, a, d, l, r, w, o, t);
                chk("rnd_cpu_timeout", l < 60, 1);
                if (!we) chk("rnd_cpu_rdata", r, e);
                chk("rnd_cpu_wait_bound", (n_vid_acks - base) <= 1, 1);
            end
            for (int k = 0; k < 30; k++) begin
                int l, w, o, base, gap; logic [7:0] r; logic [20:0] a, t;
                gap = $urandom_range(0, 2);
                repeat (gap) next_cycle();
                a = 21'h000100 + 21'($urandom_range(0, 255));
                base = n_cpu_acks;
                txn(1'b1, 1'b0, a, 8'h00, l, r, w, o, t);
                chk("rnd_vid_timeout", l < 60, 1);
                chk("rnd_vid_rdata", r, ref_rd(a));
                chk("rnd_vid_wait_bound", (n_cpu_acks - base) <= 1, 1);
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
